logic_unit_pipe: RTL and testbench
==================================

# logic_unit_pipe

Parametrised, pipelined bitwise logic unit that generalises the two-input AND/NAND gates to WIDTH-bit operands, a run-time op select and multi-beat accumulating reductions. Operands arrive on a valid/ready input stream; results leave on a valid/ready output stream through a 2-entry output buffer. It is the registered, back-pressurable gate block that the test-suite datapath circuits instantiate in place of bare combinational gates.

## Interface
- WIDTH, 8, operand and result width in bits (≥1)
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset, sampled on rising clk
- in_valid  input  1  operand beat offered
- in_ready  output  1  block can accept a beat this cycle
- in_a  input  WIDTH  operand A
- in_b  input  WIDTH  operand B
- in_op  input  3  op code: 0 AND, 1 NAND, 2 OR, 3 NOR, 4 XOR, 5 XNOR, 6 ACC_AND, 7 ACC_XOR
- in_last  input  1  final beat of an accumulation packet; ignored for ops 0-5
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- out_data  output  WIDTH  result
- out_zero  output  1  out_data == 0
- busy  output  1  accumulation open or output buffer non-empty

## Operation
- Beat accepted when in_valid && in_ready; result pushed into the output buffer when emitted; popped when out_valid && out_ready.
- Ops 0-5: bitwise on in_a/in_b; every accepted beat emits one result. NAND = ~(a&b), NOR = ~(a|b), XNOR = ~(a^b); no other inversion anywhere.
- ACC_AND: acc initialised all-ones; each beat acc = acc & in_a & in_b. ACC_XOR: acc initialised 0; each beat acc = acc ^ in_a ^ in_b.
- Accumulating beats with in_last=0 emit nothing; the in_last=1 beat emits the final acc value (including that beat's operands), then acc returns to its initial value.
- FSM: IDLE, ACC.
  - IDLE: accepted beat with op 6/7 and in_last=0 → latch op, load acc, go ACC. Op 6/7 with in_last=1 → emits single-beat result, stays IDLE. Ops 0-5 → emit, stay IDLE.
  - ACC: in_op ignored (packet op is the one latched); accepted beat with in_last=0 stays ACC; in_last=1 emits, goes IDLE.
- in_ready = (buffer count < 2) && rst_n high. Applies to non-emitting beats too.
- out_zero computed from the buffer-head entry, stored alongside data.
- busy = (state == ACC) || (count != 0).
- Reset mid-packet or with buffered results: partial acc and buffered results discarded, no output produced.

## Timing
- Reset values: out_valid 0, out_data 0, out_zero 0, busy 0, in_ready 0 while rst_n low; state IDLE, acc per op initial value, count 0.
- Latency: emitting beat accepted in cycle N → out_valid high in cycle N+1 with its result.
- Throughput: one beat per cycle while out_ready held high (count stays ≤1).
- Simultaneous push and pop at count 2 not possible (in_ready low); at count 1 count stays 1.
- Buffer is FIFO: results leave in acceptance order; out_data/out_zero stable while out_valid && !out_ready.
- in_ready depends only on registered count, never combinationally on out_ready.

## Structure
- Package logic_unit_pkg: op enum (lu_op_e, 3 bits) and accumulator initial-value function keyed on op.
- Sub-module lu_out_fifo: 2-entry FIFO, WIDTH+1 bits (data, zero flag), count output, synchronous active-low reset.
- Top holds op decode, FSM, acc register.

## Test plan
- WIDTH=8, out_ready=1, a=0xF0 b=0x3C through ops 0-5 → 0x30, 0xCF, 0xFC, 0x03, 0xCC, 0x33, each one cycle after acceptance.
- ACC_AND 3 beats (a,b)=(0xFF,0xF7),(0xFE,0xFF),(0x7F,0xFF last) → single output 0x76, out_zero 0; ops of beats 2-3 set to 0, no effect.
- ACC_XOR single beat a=0x55 b=0x55 in_last=1 → output 0x00, out_zero 1, state remains IDLE.
- out_ready=0, stream 3 AND beats → first two accepted, in_ready low after second, third held; release out_ready → results in order, third accepted.
- Reset asserted mid ACC_AND packet with 1 result buffered → next cycle out_valid 0, busy 0; fresh ACC_AND packet starts from all-ones.

Source files
------------

// File: rtl/logic_unit_pkg.sv
// Shared types for the pipelined logic unit: op codes, FSM states and
// the accumulator seed helper.
package logic_unit_pkg;

  typedef enum logic [2:0] {
    LU_AND     = 3'd0,
    LU_NAND    = 3'd1,
    LU_OR      = 3'd2,
    LU_NOR     = 3'd3,
    LU_XOR     = 3'd4,
    LU_XNOR    = 3'd5,
    LU_ACC_AND = 3'd6,
    LU_ACC_XOR = 3'd7
  } lu_op_e;

  typedef enum logic {
    LU_ST_IDLE = 1'b0,
    LU_ST_ACC  = 1'b1
  } lu_state_e;

  localparam int unsigned LU_FIFO_DEPTH = 2;

  // Fill bit of the accumulator seed: all-ones for AND reduction, zero otherwise.
  function automatic logic acc_init_bit(input lu_op_e op);
    case (op)
      LU_ACC_AND: return 1'b1;
      default:    return 1'b0;
    endcase
  endfunction

  function automatic logic is_acc_op(input lu_op_e op);
    return (op == LU_ACC_AND) || (op == LU_ACC_XOR);
  endfunction

endpackage

// File: rtl/logic_unit_pipe_if.sv
// Operand input stream and result output stream of the logic unit.
interface logic_unit_pipe_if #(parameter int WIDTH = 8);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [2:0]       in_op;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_zero;

  modport master (
    output in_valid, in_a, in_b, in_op, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_zero
  );

  modport slave (
    input  in_valid, in_a, in_b, in_op, in_last, out_ready,
    output in_ready, out_valid, out_data, out_zero
  );
endinterface

// File: rtl/lu_out_fifo.sv
// Two-entry result FIFO; head entry is presented directly as the output
// and reads as zero while empty.
module lu_out_fifo #(
  parameter int DW = 9
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic [DW-1:0] din_i,
  input  logic          pop_i,
  output logic [DW-1:0] dout_o,
  output logic          valid_o,
  output logic [1:0]    count_o
);
  logic [DW-1:0] mem_q [2];
  logic          wr_ptr_q, rd_ptr_q;
  logic [1:0]    count_q, count_d;
  logic          push_ok_s, pop_ok_s;

  assign push_ok_s = push_i && (count_q != 2'd2);
  assign pop_ok_s  = pop_i && (count_q != 2'd0);

  always_comb begin
    count_d = count_q;
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_ok_s) begin
        mem_q[wr_ptr_q] <= din_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_ok_s) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_d;
    end
  end

  assign valid_o = (count_q != 2'd0);
  assign dout_o  = valid_o ? mem_q[rd_ptr_q] : '0;
  assign count_o = count_q;
endmodule

// File: rtl/logic_unit_pipe.sv
// Pipelined bitwise logic unit: op decode, accumulation FSM and
// accumulator, feeding a two-entry output FIFO.
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  logic_unit_pipe_if.slave      bus,
  output logic                  busy
);
  lu_state_e        state_q;
  lu_op_e           op_q;
  logic [WIDTH-1:0] acc_q;

  lu_op_e           op_eff_s;
  logic [WIDTH-1:0] acc_base_s, result_s;
  logic             accept_s, is_acc_s, emit_s;
  logic [1:0]       count_s;
  logic [WIDTH:0]   fifo_dout_s;

  assign bus.in_ready = (count_s != 2'd2) && rst_n;
  assign accept_s     = bus.in_valid && bus.in_ready;

  // Inside a packet the latched op governs; the live in_op is ignored.
  always_comb begin
    op_eff_s   = (state_q == LU_ST_ACC) ? op_q : lu_op_e'(bus.in_op);
    acc_base_s = (state_q == LU_ST_ACC) ? acc_q : {WIDTH{acc_init_bit(op_eff_s)}};
    is_acc_s   = is_acc_op(op_eff_s);
    result_s   = '0;
    case (op_eff_s)
      LU_AND:     result_s = bus.in_a & bus.in_b;
      LU_NAND:    result_s = ~(bus.in_a & bus.in_b);
      LU_OR:      result_s = bus.in_a | bus.in_b;
      LU_NOR:     result_s = ~(bus.in_a | bus.in_b);
      LU_XOR:     result_s = bus.in_a ^ bus.in_b;
      LU_XNOR:    result_s = ~(bus.in_a ^ bus.in_b);
      LU_ACC_AND: result_s = acc_base_s & bus.in_a & bus.in_b;
      LU_ACC_XOR: result_s = acc_base_s ^ bus.in_a ^ bus.in_b;
      default:    result_s = '0;
    endcase
    emit_s = accept_s && (!is_acc_s || bus.in_last);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= LU_ST_IDLE;
      op_q    <= LU_ACC_AND;
      acc_q   <= {WIDTH{1'b1}};
    end else if (accept_s && is_acc_s) begin
      if (bus.in_last) begin
        state_q <= LU_ST_IDLE;
        acc_q   <= {WIDTH{acc_init_bit(op_eff_s)}};
      end else begin
        state_q <= LU_ST_ACC;
        op_q    <= op_eff_s;
        acc_q   <= result_s;
      end
    end
  end

  lu_out_fifo #(.DW(WIDTH + 1)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (emit_s),
    .din_i   ({(result_s == '0), result_s}),
    .pop_i   (bus.out_valid && bus.out_ready),
    .dout_o  (fifo_dout_s),
    .valid_o (bus.out_valid),
    .count_o (count_s)
  );

  assign {bus.out_zero, bus.out_data} = fifo_dout_s;
  assign busy = (state_q == LU_ST_ACC) || (count_s != 2'd0);
endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed and randomized bench for logic_unit_pipe against a queue-based
// reference model of the operand/result streams.
module tb_logic_unit_pipe;
  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;
  always #5 clk = ~clk;

  logic_unit_pipe_if #(.WIDTH(WIDTH)) lu_if ();
  logic_unit_pipe #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (lu_if),
    .busy  (busy)
  );

  int         n_chk = 0;
  int         n_pass = 0;
  logic [8:0] exp_q[$];
  bit         acc_open = 1'b0;
  int         pkt_op = 0;
  logic [7:0] acc_val = 8'h00;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [7:0] ref_gate(input int op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      0: return a & b;
      1: return ~(a & b);
      2: return a | b;
      3: return ~(a | b);
      4: return a ^ b;
      5: return ~(a ^ b);
      default: return 8'h00;
    endcase
  endfunction

  task automatic model_beat(input logic [7:0] a, input logic [7:0] b, input int op, input logic last);
    int eff;
    logic [7:0] r;
    eff = acc_open ? pkt_op : op;
    if (eff < 6) begin
      r = ref_gate(eff, a, b);
      exp_q.push_back({(r == 8'h00), r});
    end else begin
      if (!acc_open) acc_val = (eff == 6) ? 8'hFF : 8'h00;
      acc_val = (eff == 6) ? (acc_val & a & b) : (acc_val ^ a ^ b);
      if (last) begin
        exp_q.push_back({(acc_val == 8'h00), acc_val});
        acc_open = 1'b0;
      end else begin
        acc_open = 1'b1;
        pkt_op   = eff;
      end
    end
  endtask

  // One clock: drive, check outputs on the falling edge, advance the model.
  task automatic step(input logic rv, input logic v, input logic [7:0] a, input logic [7:0] b,
                      input int op, input logic last, input logic ordy, input logic chk);
    logic exp_rdy;
    rst_n            = rv;
    lu_if.in_valid   = v;
    lu_if.in_a       = a;
    lu_if.in_b       = b;
    lu_if.in_op      = 3'(op);
    lu_if.in_last    = last;
    lu_if.out_ready  = ordy;
    @(negedge clk);
    exp_rdy = rv && (exp_q.size() < 2);
    if (chk) begin
      chk_eq("in_ready", {31'd0, lu_if.in_ready}, {31'd0, exp_rdy});
      chk_eq("out_valid", {31'd0, lu_if.out_valid}, {31'd0, (exp_q.size() != 0)});
      if (exp_q.size() != 0) begin
        chk_eq("out_data", {24'd0, lu_if.out_data}, {24'd0, exp_q[0][7:0]});
        chk_eq("out_zero", {31'd0, lu_if.out_zero}, {31'd0, exp_q[0][8]});
      end
      chk_eq("busy", {31'd0, busy}, {31'd0, (acc_open || (exp_q.size() != 0))});
    end
    if (!rv) begin
      exp_q.delete();
      acc_open = 1'b0;
    end else begin
      if ((exp_q.size() != 0) && ordy) void'(exp_q.pop_front());
      if (v && exp_rdy) model_beat(a, b, op, last);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] gold [6];
    gold = '{8'h30, 8'hCF, 8'hFC, 8'h03, 8'hCC, 8'h33};

    step(1'b0, 1'b0, 8'h00, 8'h00, 0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 8'h00, 8'h00, 0, 1'b0, 1'b0, 1'b0);
    chk_eq("rst_out_valid", {31'd0, lu_if.out_valid}, 32'd0);
    chk_eq("rst_out_data", {24'd0, lu_if.out_data}, 32'd0);
    chk_eq("rst_out_zero", {31'd0, lu_if.out_zero}, 32'd0);
    chk_eq("rst_busy", {31'd0, busy}, 32'd0);
    chk_eq("rst_in_ready", {31'd0, lu_if.in_ready}, 32'd0);

    // Ops 0-5 on fixed operands, result visible one cycle after acceptance.
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b1, 8'hF0, 8'h3C, i, 1'b0, 1'b1, 1'b1);
      chk_eq($sformatf("op%0d_valid", i), {31'd0, lu_if.out_valid}, 32'd1);
      chk_eq($sformatf("op%0d_data", i), {24'd0, lu_if.out_data}, {24'd0, gold[i]});
    end

    // Three-beat ACC_AND packet; later beats carry op 0 which must be ignored.
    step(1'b1, 1'b1, 8'hFF, 8'hF7, 6, 1'b0, 1'b1, 1'b1);
    chk_eq("acc_b1_valid", {31'd0, lu_if.out_valid}, 32'd0);
    step(1'b1, 1'b1, 8'hFE, 8'hFF, 0, 1'b0, 1'b1, 1'b1);
    chk_eq("acc_b2_valid", {31'd0, lu_if.out_valid}, 32'd0);
    step(1'b1, 1'b1, 8'h7F, 8'hFF, 0, 1'b1, 1'b1, 1'b1);
    chk_eq("acc_and_data", {24'd0, lu_if.out_data}, 32'h76);
    chk_eq("acc_and_zero", {31'd0, lu_if.out_zero}, 32'd0);

    // Single-beat ACC_XOR packet yields zero and leaves the FSM idle.
    step(1'b1, 1'b1, 8'h55, 8'h55, 7, 1'b1, 1'b1, 1'b1);
    chk_eq("xor1_data", {24'd0, lu_if.out_data}, 32'h00);
    chk_eq("xor1_zero", {31'd0, lu_if.out_zero}, 32'd1);
    step(1'b1, 1'b0, 8'h00, 8'h00, 0, 1'b0, 1'b1, 1'b1);
    chk_eq("xor1_idle_busy", {31'd0, busy}, 32'd0);

    // Back-pressure: two beats fill the buffer, the third waits.
    step(1'b1, 1'b1, 8'hF0, 8'h3C, 0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 8'h0F, 8'hFF, 0, 1'b0, 1'b0, 1'b1);
    chk_eq("full_in_ready", {31'd0, lu_if.in_ready}, 32'd0);
    step(1'b1, 1'b1, 8'hAA, 8'hA5, 0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 8'hAA, 8'hA5, 0, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 8'hAA, 8'hA5, 0, 1'b0, 1'b1, 1'b1);
    repeat (3) step(1'b1, 1'b0, 8'h00, 8'h00, 0, 1'b0, 1'b1, 1'b1);

    // Reset during an open ACC_AND packet with a buffered result.
    step(1'b1, 1'b1, 8'h33, 8'h33, 0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 8'hF0, 8'hFF, 6, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 8'h00, 8'h00, 0, 1'b0, 1'b0, 1'b1);
    chk_eq("midrst_out_valid", {31'd0, lu_if.out_valid}, 32'd0);
    chk_eq("midrst_busy", {31'd0, busy}, 32'd0);
    step(1'b1, 1'b1, 8'hF0, 8'hFF, 6, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 8'hFF, 8'h3F, 0, 1'b1, 1'b1, 1'b1);
    chk_eq("fresh_acc_data", {24'd0, lu_if.out_data}, 32'h30);

    // Randomized traffic with occasional resets and back-pressure.
    repeat (600) begin
      step(($urandom_range(0, 99) != 0), ($urandom_range(0, 3) != 0),
           8'($urandom), 8'($urandom), int'($urandom_range(0, 7)),
           ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) != 0), 1'b1);
    end
    repeat (4) step(1'b1, 1'b0, 8'h00, 8'h00, 0, 1'b0, 1'b1, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
